alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal values 8..64, even.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 op  input  4  operation code (see REQ-010).
REQ-006 a  input  WIDTH  operand 1; captured on the accepting edge.
REQ-007 b  input  WIDTH  operand 2; captured on the accepting edge.
REQ-008 result  output  WIDTH  registered result; holds its value until the next done.
REQ-009 zero, done, busy, dz  output  1 each: result==0; one-cycle completion pulse; multi-cycle op in progress; divide-by-zero, valid with done.
REQ-009a hi, lo  output  WIDTH each  registered multiply/divide result pair.

Function
REQ-010 op codes:
- 0010 add: a+b, mod 2^WIDTH.
- 0110 sub: a+~b+1.
- 0000 and. 0001 or. 1000 xor. 1001 nor.
- 0111 slt: signed a<b, taken from the true sign of the WIDTH+1-bit difference (no overflow error).
- 1010 sltu: unsigned a<b.
- 1011 multu: unsigned.
- 1100 divu: unsigned.
- Any other code: result=0.
REQ-011 FSM states: IDLE, MUL, DIV. Reset state is IDLE.
REQ-012 Accept rule: start=1 in IDLE at edge E0 accepts the request. start while busy=1 is ignored and not queued.
REQ-013 Single-cycle ops (all except multu/divu):
- result, zero and done=1 are registered at E0.
- Latency 1; the FSM stays in IDLE.
- hi and lo are unchanged.
REQ-014 multu at E0:
- Capture a and b; clear the accumulator; go to MUL; busy=1 from E0.
- Perform one shift-add iteration per edge, E1..E_WIDTH.
- At E_WIDTH: {hi,lo}=a*b (full 2*WIDTH bits); result=lo; zero=(lo==0); done=1; busy=0; go to IDLE.
REQ-015 divu with b!=0 at E0:
- Go to DIV; busy=1 from E0.
- Perform one restoring-division iteration per edge, E1..E_WIDTH.
- At E_WIDTH: lo=quotient, hi=remainder, result=quotient, zero=(quotient==0), done=1, busy=0; go to IDLE.
REQ-016 divu with b==0 at E0:
- No iteration; complete at E0 (latency 1).
- lo = all ones, hi = a, result = all ones, dz=1, done=1, zero=0.
REQ-017 dz=0 on every completion other than REQ-016; dz is cleared on the next done.
REQ-018 done is high for exactly one cycle per accepted request and is never asserted while busy=1.
REQ-019 Back-to-back: start=1 in the cycle where done=1 (busy=0) is accepted, giving a single-cycle op throughput of 1 per clock.
REQ-020 Operand changes on a/b after the accepting edge do not affect an in-flight multu/divu.
REQ-021 zero is always registered with result, never computed combinationally from the output.

Reset
REQ-022 While rst=1 at an edge:
- The FSM goes to IDLE.
- result, hi, lo, the iteration counter and the internal accumulators are cleared to 0.
- zero=1; done=0; busy=0; dz=0.
REQ-023 rst overrides start at the same edge; the request is dropped.
REQ-024 rst during MUL/DIV aborts the operation: no done is issued and hi/lo are cleared.

Verification (WIDTH=32)
REQ-025 rst, then start with op=0110, a=5, b=5 -> next cycle: result=0, zero=1, done=1 for one cycle, busy=0.
REQ-026 op=0111, a=0xFFFFFFFF, b=1 -> result=1; op=1010 with the same operands -> result=0; op=0111, a=0x80000000, b=0x7FFFFFFF -> result=1.
REQ-027 multu, a=0xFFFFFFFF, b=0xFFFFFFFF -> busy=1 for 32 cycles, then done=1, hi=0xFFFFFFFE, lo=0x00000001, result=1; start pulses issued during busy are ignored.
REQ-028 divu, a=100, b=7 -> done after 32 busy cycles, lo=14, hi=2, dz=0. divu, a=9, b=0 -> done next cycle, lo=0xFFFFFFFF, hi=9, dz=1.
REQ-029 Start multu, assert rst at cycle 10 of busy -> no done pulse; busy=0, hi=lo=result=0, zero=1 after the reset edge; a following add 3+4 returns result=7 next cycle.
REQ-030 Repeat REQ-025 to REQ-028 with WIDTH=16 (16 busy cycles); add 0xFFFF+1 -> result=0, zero=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: single-cycle ALU with iterative shift-add multiply and restoring divide
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             done,
  output logic             busy,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo, alu, rem_next, quo_next, fin_hi, fin_lo;
  logic [WIDTH:0] mul_sum, div_sh, div_d;
  logic [2*WIDTH-1:0] mul_next;
  logic go, is_mul, is_div, last;
  assign busy   = state != IDLE;
  assign go     = start && state == IDLE;
  assign is_mul = op == 4'b1011;
  assign is_div = op == 4'b1100;
  assign last   = cnt == CW'(WIDTH - 1);
  // single-cycle operation results
  always_comb begin
    alu = '0;
    case (op)
      4'b0010: alu = a + b;
      4'b0110: alu = a - b;
      4'b0000: alu = a & b;
      4'b0001: alu = a | b;
      4'b1000: alu = a ^ b;
      4'b1001: alu = ~(a | b);
      4'b0111: alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1010: alu = {{(WIDTH-1){1'b0}}, a < b};
      default: alu = '0;
    endcase
  end
  // one multiply or divide iteration; acc_hi/acc_lo hold the partial product or remainder/quotient
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc_lo[WIDTH-1:1]};
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_d    = div_sh - {1'b0, opnd};
    rem_next = div_d[WIDTH] ? div_sh[WIDTH-1:0] : div_d[WIDTH-1:0];
    quo_next = {acc_lo[WIDTH-2:0], ~div_d[WIDTH]};
    fin_hi   = state == MUL ? mul_next[2*WIDTH-1:WIDTH] : rem_next;
    fin_lo   = state == MUL ? mul_next[WIDTH-1:0] : quo_next;
  end
  // next-state selection
  always_comb begin
    state_next = state == IDLE ? (go && is_mul ? MUL : go && is_div && b != '0 ? DIV : IDLE)
                               : (last ? IDLE : state);
  end
  // state, datapath and completion registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      result <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
      dz     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (go) begin
        cnt    <= '0;
        acc_hi <= '0;
        opnd   <= is_mul ? a : b;
        acc_lo <= is_mul ? b : a;
        if (is_div && b == '0) begin
          lo     <= '1;
          hi     <= a;
          result <= '1;
          zero   <= 1'b0;
          dz     <= 1'b1;
          done   <= 1'b1;
        end else if (!is_mul && !is_div) begin
          result <= alu;
          zero   <= alu == '0;
          dz     <= 1'b0;
          done   <= 1'b1;
        end
      end else if (busy) begin
        cnt    <= cnt + CW'(1);
        acc_hi <= fin_hi;
        acc_lo <= fin_lo;
        if (last) begin
          hi     <= fin_hi;
          lo     <= fin_lo;
          result <= fin_lo;
          zero   <= fin_lo == '0;
          dz     <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table, hand sequences and randomized checks of alu_seq at WIDTH 32 and 16
module tb_alu_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, s32, s16;
  logic [3:0] op;
  logic [31:0] a, b, r32, h32, l32;
  logic [15:0] r16, h16, l16;
  logic z32, d32, bz32, dz32, z16, d16, bz16, dz16;
  alu_seq #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .start(s32), .op(op), .a(a), .b(b),
    .result(r32), .zero(z32), .done(d32), .busy(bz32), .dz(dz32), .hi(h32), .lo(l32));
  alu_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .start(s16), .op(op), .a(a[15:0]), .b(b[15:0]),
    .result(r16), .zero(z16), .done(d16), .busy(bz16), .dz(dz16), .hi(h16), .lo(l16));
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r, h, l;
    logic        d;
    bit          hl;
    int          lat;
  } vec_t;
  vec_t tbl32 [18];
  vec_t tbl16 [8];
  int tests = 0, fails = 0;
  logic [63:0] ehi [2];
  logic [63:0] elo [2];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // reference: plain arithmetic on w-bit values held in 64-bit variables
  function automatic void model(input int w, input logic [3:0] o, input logic [63:0] x, y,
                                output logic [63:0] r, h, l, output logic d, output bit hl, output int lat);
    logic [63:0] m;
    longint sx, sy;
    m = (64'd1 << w) - 64'd1;
    sx = longint'(x << (64 - w)) >>> (64 - w);
    sy = longint'(y << (64 - w)) >>> (64 - w);
    r = 0; h = 0; l = 0; d = 0; hl = 0; lat = 1;
    case (o)
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b1000: r = x ^ y;
      4'b1001: r = ~(x | y);
      4'b0111: r = 64'(sx < sy);
      4'b1010: r = 64'(x < y);
      4'b1011: begin hl = 1; lat = w + 1; l = x * y; h = l >> w; end
      4'b1100: begin
        hl = 1;
        if (y == 0) begin d = 1; l = m; h = x; end
        else begin lat = w + 1; l = x / y; h = x % y; end
      end
      default: r = 0;
    endcase
    if (hl) r = l;
    r &= m; h &= m; l &= m;
  endfunction
  task automatic apply(input int w, input logic [3:0] o, input logic [63:0] x, y, er, eh, el,
                       input logic ed, input bit hl, input int lat, input string nm);
    int k, cyc, nb;
    logic dn, by;
    k = (w == 16) ? 1 : 0;
    cyc = 0; nb = 0;
    if (hl) begin ehi[k] = eh; elo[k] = el; end
    @(negedge clk);
    op = o; a = x[31:0]; b = y[31:0];
    if (k == 1) s16 = 1; else s32 = 1;
    do begin
      @(negedge clk);
      cyc++; s32 = 0; s16 = 0; a = $urandom; b = $urandom;
      dn = k == 1 ? d16 : d32;
      by = k == 1 ? bz16 : bz32;
      chk({nm, " done_while_busy"}, 64'(dn & by), 64'd0);
      if (by) begin
        nb++; op = 4'b0010;
        if ($urandom_range(0, 1) == 1) begin if (k == 1) s16 = 1; else s32 = 1; end
      end
    end while (!dn && cyc < 100);
    chk({nm, " latency"}, 64'(cyc), 64'(lat));
    chk({nm, " busy_cycles"}, 64'(nb), 64'(lat - 1));
    chk({nm, " result"}, k == 1 ? 64'(r16) : 64'(r32), er);
    chk({nm, " zero"}, 64'(k == 1 ? z16 : z32), 64'(er == 0));
    chk({nm, " dz"}, 64'(k == 1 ? dz16 : dz32), 64'(ed));
    chk({nm, " hi"}, k == 1 ? 64'(h16) : 64'(h32), ehi[k]);
    chk({nm, " lo"}, k == 1 ? 64'(l16) : 64'(l32), elo[k]);
    @(negedge clk);
    chk({nm, " done_pulse"}, 64'(k == 1 ? d16 : d32), 64'd0);
  endtask
  task automatic run_vec(input int w, input vec_t v, input string nm);
    apply(w, v.op, 64'(v.a), 64'(v.b), 64'(v.r), 64'(v.h), 64'(v.l), v.d, v.hl, v.lat, nm);
  endtask
  task automatic rnd(input int w);
    logic [63:0] m, x, y, r, h, l;
    logic d;
    bit hl;
    int lat;
    logic [3:0] o;
    m = (64'd1 << w) - 64'd1;
    o = ($urandom_range(0, 2) == 0) ? ($urandom_range(0, 1) == 1 ? 4'b1011 : 4'b1100) : 4'($urandom_range(0, 15));
    x = 64'($urandom) & m;
    y = ($urandom_range(0, 5) == 0) ? 64'($urandom_range(0, 3)) : 64'($urandom) & m;
    model(w, o, x, y, r, h, l, d, hl, lat);
    apply(w, o, x, y, r, h, l, d, hl, lat, "rand");
  endtask
  initial begin
    int cnt;
    tbl32[0]  = '{4'b0110, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl32[1]  = '{4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl32[2]  = '{4'b1010, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl32[3]  = '{4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl32[4]  = '{4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl32[5]  = '{4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl32[6]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl32[7]  = '{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl32[8]  = '{4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl32[9]  = '{4'b1001, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl32[10] = '{4'b1111, 32'd12, 32'd34, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl32[11] = '{4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 32'd1, 1'b0, 1'b1, 33};
    tbl32[12] = '{4'b1100, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 1'b0, 1'b1, 33};
    tbl32[13] = '{4'b1100, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 32'hFFFFFFFF, 1'b1, 1'b1, 1};
    tbl32[14] = '{4'b0010, 32'h12345678, 32'h11111111, 32'h23456789, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl32[15] = '{4'b1100, 32'd5, 32'd100, 32'd0, 32'd5, 32'd0, 1'b0, 1'b1, 33};
    tbl32[16] = '{4'b1011, 32'h00010000, 32'h00010000, 32'd0, 32'd1, 32'd0, 1'b0, 1'b1, 33};
    tbl32[17] = '{4'b0110, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl16[0] = '{4'b0110, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl16[1] = '{4'b0111, 32'hFFFF, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl16[2] = '{4'b1010, 32'hFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl16[3] = '{4'b0111, 32'h8000, 32'h7FFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    tbl16[4] = '{4'b1011, 32'hFFFF, 32'hFFFF, 32'd1, 32'hFFFE, 32'd1, 1'b0, 1'b1, 17};
    tbl16[5] = '{4'b1100, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 1'b0, 1'b1, 17};
    tbl16[6] = '{4'b1100, 32'd9, 32'd0, 32'hFFFF, 32'd9, 32'hFFFF, 1'b1, 1'b1, 1};
    tbl16[7] = '{4'b0010, 32'hFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1};
    ehi[0] = 0; ehi[1] = 0; elo[0] = 0; elo[1] = 0;
    rst = 1; s32 = 0; s16 = 0; op = 0; a = 0; b = 0;
    repeat (2) @(negedge clk);
    chk("reset result", 64'(r32), 0);
    chk("reset zero", 64'(z32), 1);
    chk("reset done", 64'(d32), 0);
    chk("reset busy", 64'(bz32), 0);
    chk("reset dz", 64'(dz32), 0);
    chk("reset hi", 64'(h32), 0);
    chk("reset lo", 64'(l32), 0);
    chk("reset16 zero", 64'(z16), 1);
    chk("reset16 result", 64'(r16), 0);
    rst = 0;
    for (int i = 0; i < 18; i++) run_vec(32, tbl32[i], $sformatf("vec32_%0d", i));
    for (int i = 0; i < 8; i++) run_vec(16, tbl16[i], $sformatf("vec16_%0d", i));
    @(negedge clk);
    op = 4'b0010; a = 1; b = 2; s32 = 1;
    @(negedge clk);
    chk("b2b first done", 64'(d32), 1);
    chk("b2b first result", 64'(r32), 3);
    op = 4'b0110; a = 10; b = 3;
    @(negedge clk);
    s32 = 0;
    chk("b2b second done", 64'(d32), 1);
    chk("b2b second result", 64'(r32), 7);
    @(negedge clk);
    chk("b2b done drop", 64'(d32), 0);
    rst = 1; s32 = 1; op = 4'b0010; a = 1; b = 1;
    @(negedge clk);
    rst = 0; s32 = 0;
    chk("rst_over_start done", 64'(d32), 0);
    chk("rst_over_start result", 64'(r32), 0);
    @(negedge clk);
    chk("rst_over_start dropped", 64'(d32), 0);
    chk("rst_over_start busy", 64'(bz32), 0);
    op = 4'b1011; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; s32 = 1;
    @(negedge clk);
    s32 = 0;
    repeat (9) @(negedge clk);
    chk("abort busy before rst", 64'(bz32), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    ehi[0] = 0; ehi[1] = 0; elo[0] = 0; elo[1] = 0;
    chk("abort busy", 64'(bz32), 0);
    chk("abort hi", 64'(h32), 0);
    chk("abort lo", 64'(l32), 0);
    chk("abort result", 64'(r32), 0);
    chk("abort zero", 64'(z32), 1);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (d32) cnt++;
    end
    chk("abort no done", 64'(cnt), 0);
    apply(32, 4'b0010, 64'd3, 64'd4, 64'd7, 0, 0, 1'b0, 1'b0, 1, "after_abort add");
    for (int i = 0; i < 40; i++) rnd(32);
    for (int i = 0; i < 40; i++) rnd(16);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
